// File: rtl/dtw_accel_s00_axis_rx.sv
// AXI4-Stream slave receiving DTW sample words into a circular FIFO with
// per-word last flags, popped by the DTW core; checks fixed-length packet framing.
module dtw_accel_s00_axis_rx #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int PKT_WORDS            = 8
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESET,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic                                dtw_fifo_rden,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     dtw_fifo_dout,
  output logic                                dtw_fifo_dout_last,
  output logic                                dtw_fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]         dtw_fifo_count,
  output logic                                pkt_done,
  output logic                                pkt_err,
  input  logic                                err_clr
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int BCNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int DW     = C_S_AXIS_TDATA_WIDTH;
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [BCNT_W-1:0] LAST_BEAT_C = BCNT_W'(PKT_WORDS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  logic [DW:0]        mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [BCNT_W-1:0]  beat_cnt_r;
  state_t             state_r;
  logic               tready_r;
  logic [DW-1:0]      dout_r;
  logic               dout_last_r;
  logic               empty_r;
  logic               pkt_done_r;
  logic               pkt_err_r;

  logic               accept_s;
  logic               pop_s;
  logic               at_last_beat_s;
  logic               boundary_s;
  logic               frame_err_s;
  logic [CNT_W-1:0]   count_next_s;
  logic               unused_tstrb_s;

  // TSTRB is accepted but every byte is treated as data.
  assign unused_tstrb_s = ^S_AXIS_TSTRB;

  // Handshake, framing decode and next-state occupancy.
  always_comb begin
    accept_s       = S_AXIS_TVALID && tready_r;
    pop_s          = dtw_fifo_rden && !empty_r;
    at_last_beat_s = (beat_cnt_r == LAST_BEAT_C);
    boundary_s     = S_AXIS_TLAST || at_last_beat_s;
    frame_err_s    = accept_s && (S_AXIS_TLAST != at_last_beat_s);
    count_next_s   = count_r;
    case ({accept_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= {boundary_s, S_AXIS_TDATA};
    end
  end

  // Pointers, occupancy, ready and registered read port.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      tready_r    <= 1'b0;
      empty_r     <= 1'b1;
      dout_r      <= '0;
      dout_last_r <= 1'b0;
    end else begin
      count_r  <= count_next_s;
      empty_r  <= (count_next_s == CNT_W'(0));
      // Ready looks at next-state count so it drops the cycle the FIFO fills.
      tready_r <= (count_next_s < DEPTH_C);
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r    <= rd_ptr_r + ADDR_W'(1);
        dout_r      <= mem_r[rd_ptr_r][DW-1:0];
        dout_last_r <= mem_r[rd_ptr_r][DW];
      end
    end
  end

  // Packet framing state machine with done pulse and sticky error.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_r    <= ST_IDLE;
      beat_cnt_r <= '0;
      pkt_done_r <= 1'b0;
      pkt_err_r  <= 1'b0;
    end else begin
      pkt_done_r <= accept_s && boundary_s;
      if (frame_err_s) begin
        pkt_err_r <= 1'b1;
      end else if (err_clr) begin
        pkt_err_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s && !boundary_s) begin
            beat_cnt_r <= BCNT_W'(1);
            state_r    <= ST_RECV;
          end else begin
            beat_cnt_r <= '0;
            state_r    <= ST_IDLE;
          end
        end
        ST_RECV: begin
          if (accept_s) begin
            if (boundary_s) begin
              beat_cnt_r <= '0;
              state_r    <= ST_IDLE;
            end else begin
              beat_cnt_r <= beat_cnt_r + BCNT_W'(1);
              state_r    <= ST_RECV;
            end
          end
        end
        default: begin
          beat_cnt_r <= '0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign S_AXIS_TREADY      = tready_r;
  assign dtw_fifo_dout      = dout_r;
  assign dtw_fifo_dout_last = dout_last_r;
  assign dtw_fifo_empty     = empty_r;
  assign dtw_fifo_count     = count_r;
  assign pkt_done           = pkt_done_r;
  assign pkt_err            = pkt_err_r;

endmodule

// File: tb/tb_dtw_accel_s00_axis_rx.sv
// Directed self-checking bench for dtw_accel_s00_axis_rx (32-bit, depth 16, 8-word packets).
module tb_dtw_accel_s00_axis_rx;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          areset;
  logic [W-1:0]  tdata;
  logic [3:0]    tstrb;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic          rden;
  logic [W-1:0]  dout;
  logic          dout_last;
  logic          empty;
  logic [4:0]    count;
  logic          pkt_done;
  logic          pkt_err;
  logic          err_clr;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  always #5 clk = ~clk;

  dtw_accel_s00_axis_rx #(
    .C_S_AXIS_TDATA_WIDTH(32),
    .FIFO_DEPTH(16),
    .PKT_WORDS(8)
  ) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESET(areset),
    .S_AXIS_TDATA(tdata),
    .S_AXIS_TSTRB(tstrb),
    .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready),
    .dtw_fifo_rden(rden),
    .dtw_fifo_dout(dout),
    .dtw_fifo_dout_last(dout_last),
    .dtw_fifo_empty(empty),
    .dtw_fifo_count(count),
    .pkt_done(pkt_done),
    .pkt_err(pkt_err),
    .err_clr(err_clr)
  );

  // Count done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (pkt_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    areset = 1'b1; tvalid = 1'b0; tlast = 1'b0; rden = 1'b0; err_clr = 1'b0;
    tick;
    areset = 1'b0;
    tick;
  endtask

  // Drives one beat and waits (bounded) until the slave takes it.
  task automatic send_beat(input logic [W-1:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    tdata = d; tlast = l; tvalid = 1'b1;
    for (int i = 0; i < 32 && !ok; i++) begin
      ok = tready;
      tick;
    end
    tvalid = 1'b0; tlast = 1'b0;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL send_beat: data %h accepted=0 required=1", d); end
  endtask

  task automatic test_reset;
    areset = 1'b1; tvalid = 1'b0; tlast = 1'b0; rden = 1'b0; err_clr = 1'b0;
    tdata = '0; tstrb = 4'hF;
    tick; tick;
    tests_run++; if (tready !== 1'b0) begin tests_failed++; $display("FAIL reset_tready: got %b exp 0", tready); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b exp 1", empty); end
    tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d exp 0", count); end
    tests_run++; if (dout !== 32'h0 || dout_last !== 1'b0) begin tests_failed++; $display("FAIL reset_dout: got %h/%b exp 0/0", dout, dout_last); end
    tests_run++; if (pkt_done !== 1'b0 || pkt_err !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got done=%b err=%b exp 0/0", pkt_done, pkt_err); end
    areset = 1'b0;
    tick;
    tests_run++; if (tready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_tready: got %b exp 1", tready); end
  endtask

  task automatic test_single_packet;
    int base;
    do_reset;
    base = done_cnt;
    for (int i = 0; i < 8; i++) send_beat(32'h10 + 32'(i), (i == 7));
    tests_run++; if (pkt_done !== 1'b1) begin tests_failed++; $display("FAIL single_done_pulse: got %b exp 1", pkt_done); end
    tests_run++; if (count !== 5'd8 || tready !== 1'b1) begin tests_failed++; $display("FAIL single_count: got %0d/%b exp 8/1", count, tready); end
    tick;
    tests_run++; if (done_cnt - base !== 1 || pkt_done !== 1'b0) begin tests_failed++; $display("FAIL single_done_once: got %0d/%b exp 1/0", done_cnt - base, pkt_done); end
    rden = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      tests_run++;
      if (dout !== 32'h10 + 32'(i) || dout_last !== (i == 7)) begin
        tests_failed++; $display("FAIL single_pop%0d: got %h/%b exp %h/%b", i, dout, dout_last, 32'h10 + 32'(i), (i == 7));
      end
    end
    rden = 1'b0;
    tests_run++; if (empty !== 1'b1 || count !== 5'd0 || pkt_err !== 1'b0) begin tests_failed++; $display("FAIL single_drained: got empty=%b count=%0d err=%b exp 1/0/0", empty, count, pkt_err); end
  endtask

  task automatic test_backpressure;
    do_reset;
    for (int i = 0; i < 16; i++) send_beat(32'h100 + 32'(i), 1'b0);
    tests_run++; if (count !== 5'd16 || tready !== 1'b0) begin tests_failed++; $display("FAIL bp_full: got %0d/%b exp 16/0", count, tready); end
    tdata = 32'h110; tlast = 1'b0; tvalid = 1'b1;
    tick; tick;
    tests_run++; if (count !== 5'd16) begin tests_failed++; $display("FAIL bp_hold: got %0d exp 16", count); end
    rden = 1'b1;
    tick;
    rden = 1'b0;
    tests_run++; if (dout !== 32'h100 || count !== 5'd15 || tready !== 1'b1) begin tests_failed++; $display("FAIL bp_pop: got %h/%0d/%b exp 100/15/1", dout, count, tready); end
    tick;
    tvalid = 1'b0;
    tests_run++; if (count !== 5'd16 || tready !== 1'b0) begin tests_failed++; $display("FAIL bp_17th: got %0d/%b exp 16/0", count, tready); end
    rden = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick;
      tests_run++;
      if (dout !== 32'h101 + 32'(i)) begin tests_failed++; $display("FAIL bp_drain%0d: got %h exp %h", i, dout, 32'h101 + 32'(i)); end
    end
    rden = 1'b0;
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL bp_empty: got %b exp 1", empty); end
  endtask

  task automatic test_short_packet;
    int base;
    do_reset;
    base = done_cnt;
    for (int i = 0; i < 5; i++) begin
      send_beat(32'h50 + 32'(i), (i == 4));
      if (i == 3) begin
        tests_run++; if (pkt_err !== 1'b0) begin tests_failed++; $display("FAIL short_err_early: got %b exp 0", pkt_err); end
      end
    end
    tests_run++; if (pkt_err !== 1'b1 || pkt_done !== 1'b1) begin tests_failed++; $display("FAIL short_flags: got err=%b done=%b exp 1/1", pkt_err, pkt_done); end
    rden = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      tests_run++;
      if (dout !== 32'h50 + 32'(i) || dout_last !== (i == 4)) begin
        tests_failed++; $display("FAIL short_pop%0d: got %h/%b exp %h/%b", i, dout, dout_last, 32'h50 + 32'(i), (i == 4));
      end
    end
    rden = 1'b0;
    tests_run++; if (done_cnt - base !== 1) begin tests_failed++; $display("FAIL short_done_cnt: got %0d exp 1", done_cnt - base); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    tests_run++; if (pkt_err !== 1'b0) begin tests_failed++; $display("FAIL short_clr: got %b exp 0", pkt_err); end
    // A fresh framing error in the clearing cycle keeps the flag set.
    err_clr = 1'b1;
    send_beat(32'h77, 1'b1);
    err_clr = 1'b0;
    tests_run++; if (pkt_err !== 1'b1) begin tests_failed++; $display("FAIL short_set_wins: got %b exp 1", pkt_err); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    tests_run++; if (pkt_err !== 1'b0) begin tests_failed++; $display("FAIL short_clr2: got %b exp 0", pkt_err); end
  endtask

  task automatic test_long_packet;
    int base;
    do_reset;
    base = done_cnt;
    for (int i = 0; i < 10; i++) begin
      send_beat(32'h200 + 32'(i), (i == 9));
      if (i == 6) begin
        tests_run++; if (pkt_err !== 1'b0) begin tests_failed++; $display("FAIL long_err_early: got %b exp 0", pkt_err); end
      end
      if (i == 7) begin
        tests_run++; if (pkt_err !== 1'b1 || pkt_done !== 1'b1) begin tests_failed++; $display("FAIL long_forced: got err=%b done=%b exp 1/1", pkt_err, pkt_done); end
      end
    end
    tick;
    tests_run++; if (done_cnt - base !== 2) begin tests_failed++; $display("FAIL long_done_cnt: got %0d exp 2", done_cnt - base); end
    rden = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      tests_run++;
      if (dout !== 32'h200 + 32'(i) || dout_last !== (i == 7 || i == 9)) begin
        tests_failed++; $display("FAIL long_pop%0d: got %h/%b exp %h/%b", i, dout, dout_last, 32'h200 + 32'(i), (i == 7 || i == 9));
      end
    end
    rden = 1'b0;
  endtask

  task automatic test_concurrent;
    logic [W-1:0] exp_d;
    do_reset;
    for (int i = 0; i < 16; i++) send_beat(32'h300 + 32'(i), 1'b0);
    // Full: a pop frees a slot but the waiting beat is not written this cycle.
    tdata = 32'h400; tvalid = 1'b1; rden = 1'b1;
    tick;
    tests_run++; if (dout !== 32'h300 || count !== 5'd15 || tready !== 1'b1) begin tests_failed++; $display("FAIL conc_full_pop: got %h/%0d/%b exp 300/15/1", dout, count, tready); end
    for (int j = 0; j < 20; j++) begin
      tdata = 32'h400 + 32'(j);
      tick;
      exp_d = (j < 15) ? 32'h301 + 32'(j) : 32'h400 + 32'(j - 15);
      tests_run++;
      if (dout !== exp_d || count !== 5'd15) begin tests_failed++; $display("FAIL conc_wrap%0d: got %h/%0d exp %h/15", j, dout, count, exp_d); end
    end
    tvalid = 1'b0;
    for (int j = 0; j < 14; j++) tick;
    tests_run++; if (dout !== 32'h412 || count !== 5'd1) begin tests_failed++; $display("FAIL conc_drain: got %h/%0d exp 412/1", dout, count); end
    tdata = 32'h500; tvalid = 1'b1;
    tick;
    tests_run++; if (dout !== 32'h413 || count !== 5'd1) begin tests_failed++; $display("FAIL conc_one_a: got %h/%0d exp 413/1", dout, count); end
    tdata = 32'h501;
    tick;
    tvalid = 1'b0;
    tests_run++; if (dout !== 32'h500 || count !== 5'd1) begin tests_failed++; $display("FAIL conc_one_b: got %h/%0d exp 500/1", dout, count); end
    tick;
    tests_run++; if (dout !== 32'h501 || count !== 5'd0 || empty !== 1'b1) begin tests_failed++; $display("FAIL conc_last: got %h/%0d/%b exp 501/0/1", dout, count, empty); end
    tick;
    rden = 1'b0;
    tests_run++; if (dout !== 32'h501 || count !== 5'd0) begin tests_failed++; $display("FAIL conc_rden_empty: got %h/%0d exp 501/0", dout, count); end
  endtask

  task automatic test_reset_mid_packet;
    int base;
    do_reset;
    base = done_cnt;
    for (int i = 0; i < 3; i++) send_beat(32'h600 + 32'(i), 1'b0);
    areset = 1'b1;
    tick;
    areset = 1'b0;
    tests_run++; if (count !== 5'd0 || empty !== 1'b1 || tready !== 1'b0) begin tests_failed++; $display("FAIL mid_reset: got %0d/%b/%b exp 0/1/0", count, empty, tready); end
    tick;
    tests_run++; if (tready !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_ready: got %b exp 1", tready); end
    for (int i = 0; i < 8; i++) send_beat(32'h700 + 32'(i), (i == 7));
    tick;
    tests_run++; if (done_cnt - base !== 1 || pkt_err !== 1'b0 || count !== 5'd8) begin tests_failed++; $display("FAIL mid_new_pkt: got done=%0d err=%b count=%0d exp 1/0/8", done_cnt - base, pkt_err, count); end
    rden = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      tests_run++;
      if (dout !== 32'h700 + 32'(i) || dout_last !== (i == 7)) begin
        tests_failed++; $display("FAIL mid_pop%0d: got %h/%b exp %h/%b", i, dout, dout_last, 32'h700 + 32'(i), (i == 7));
      end
    end
    rden = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_packet;
    test_backpressure;
    test_short_packet;
    test_long_packet;
    test_concurrent;
    test_reset_mid_packet;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
